// File: rtl/motor_dac_pkg.sv
// rtl/motor_dac_pkg.sv - shared FSM encoding and frame constants for the motor DAC SPI transmitter
package motor_dac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } dac_state_e;

    localparam int          MOTOR_VOL_DEF = 16;
    localparam int          FRAME_BITS    = 8 + MOTOR_VOL_DEF;
    localparam logic [7:0]  CMD_WORD_DEF  = 8'h30;

endpackage

// File: rtl/motor_dac_sclk_gen.sv
// rtl/motor_dac_sclk_gen.sv - SCLK half-period divider issuing fall and period-end (rise) strobes
module motor_dac_sclk_gen #(
    parameter int SCLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    localparam int CW = $clog2(2 * SCLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counter sits at zero while disabled so each SHIFT entry starts a fresh high half.
    always_comb begin
        cnt_d      = '0;
        rise_stb_o = 1'b0;
        fall_stb_o = 1'b0;
        if (en_i) begin
            fall_stb_o = (cnt_q == CW'(SCLK_DIV - 1));
            rise_stb_o = (cnt_q == CW'(2 * SCLK_DIV - 1));
            cnt_d      = rise_stb_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/motor_dac_spi_tx.sv
// rtl/motor_dac_spi_tx.sv - serialises motor samples to the SPI DAC as {CMD_WORD, data} frames
// Optional MOTOR_DAC_OFFSET_BINARY_EN: send the data field as offset binary instead of two's complement.
module motor_dac_spi_tx
    import motor_dac_pkg::*;
#(
    parameter int         MOTOR_VOL = MOTOR_VOL_DEF,
    parameter logic [7:0] CMD_WORD  = CMD_WORD_DEF,
    parameter int         SCLK_DIV  = 2,
    parameter int         CS_SETUP  = 1,
    parameter int         CS_HOLD   = 1,
    parameter int         CS_GAP    = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 motor_dac_en_i,
    input  logic [MOTOR_VOL-1:0] motor_dac_data_i,
    output logic                 dac_sclk_o,
    output logic                 dac_csn_o,
    output logic                 dac_mosi_o,
    output logic                 dac_busy_o,
    output logic                 dac_done_o,
    output logic                 dac_overrun_o
);

    localparam int FBITS = 8 + MOTOR_VOL;
    localparam int BCW   = $clog2(FBITS);

    dac_state_e            state_q, state_d;
    logic [7:0]            wait_q, wait_d;
    logic [BCW-1:0]        bit_q, bit_d;
    logic [FBITS-1:0]      shift_q, shift_d;
    logic [MOTOR_VOL-1:0]  pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  sclk_q, sclk_d;
    logic                  csn_q, csn_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovr_q, ovr_d;

    logic                  rise_stb, fall_stb;
    logic                  consume;
    logic [FBITS-1:0]      frame_word;

`ifdef MOTOR_DAC_OFFSET_BINARY_EN
    assign frame_word = {CMD_WORD, ~pend_q[MOTOR_VOL-1], pend_q[MOTOR_VOL-2:0]};
`else
    assign frame_word = {CMD_WORD, pend_q};
`endif

    assign consume = (state_q == ST_IDLE) && pend_vld_q;

    motor_dac_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (state_q == ST_SHIFT),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            sclk_q     <= 1'b0;
            csn_q      <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sclk_q     <= sclk_d;
            csn_q      <= csn_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
        end
    end

    // wait_d falls back to zero on every transition, so each timed state counts from 0.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        bit_d   = bit_q;
        case (state_q)
            ST_IDLE: begin
                bit_d = '0;
                if (pend_vld_q) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (wait_q == 8'(CS_SETUP - 1)) state_d = ST_SHIFT;
                else                            wait_d  = wait_q + 1'b1;
            end
            ST_SHIFT: begin
                if (rise_stb) begin
                    if (bit_q == BCW'(FBITS - 1)) state_d = ST_HOLD;
                    else                          bit_d   = bit_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (wait_q == 8'(CS_HOLD - 1)) state_d = ST_GAP;
                else                           wait_d  = wait_q + 1'b1;
            end
            ST_GAP: begin
                if (wait_q == 8'(CS_GAP - 1)) state_d = ST_IDLE;
                else                          wait_d  = wait_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sclk_d  = sclk_q;
        csn_d   = csn_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (pend_vld_q) begin
                    shift_d = {frame_word[FBITS-2:0], 1'b0};
                    csn_d   = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = frame_word[FBITS-1];
                end
            end
            ST_SETUP: begin
                if (state_d == ST_SHIFT) sclk_d = 1'b1;
            end
            ST_SHIFT: begin
                if (fall_stb) sclk_d = 1'b0;
                if (rise_stb && (state_d == ST_SHIFT)) begin
                    sclk_d  = 1'b1;
                    mosi_d  = shift_q[FBITS-1];
                    shift_d = {shift_q[FBITS-2:0], 1'b0};
                end
            end
            ST_HOLD: begin
                if (state_d == ST_GAP) begin
                    csn_d  = 1'b1;
                    mosi_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (state_d == ST_IDLE) busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    // A capture in the same cycle IDLE consumes the buffer is a fresh sample, not an overwrite.
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ovr_d      = 1'b0;
        if (consume) pend_vld_d = 1'b0;
        if (motor_dac_en_i) begin
            pend_d     = motor_dac_data_i;
            pend_vld_d = 1'b1;
            ovr_d      = pend_vld_q && !consume;
        end
    end

    assign dac_sclk_o    = sclk_q;
    assign dac_csn_o     = csn_q;
    assign dac_mosi_o    = mosi_q;
    assign dac_busy_o    = busy_q;
    assign dac_done_o    = done_q;
    assign dac_overrun_o = ovr_q;

endmodule

// File: tb/tb_motor_dac_spi_tx.sv
// tb/tb_motor_dac_spi_tx.sv - scoreboard bench for motor_dac_spi_tx (honours MOTOR_DAC_OFFSET_BINARY_EN)
module tb_motor_dac_spi_tx;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        motor_dac_en_i = 1'b0;
    logic [15:0] motor_dac_data_i = '0;
    logic        dac_sclk_o, dac_csn_o, dac_mosi_o, dac_busy_o, dac_done_o, dac_overrun_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    motor_dac_spi_tx dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .motor_dac_en_i   (motor_dac_en_i),
        .motor_dac_data_i (motor_dac_data_i),
        .dac_sclk_o       (dac_sclk_o),
        .dac_csn_o        (dac_csn_o),
        .dac_mosi_o       (dac_mosi_o),
        .dac_busy_o       (dac_busy_o),
        .dac_done_o       (dac_done_o),
        .dac_overrun_o    (dac_overrun_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_frame(input logic [15:0] d);
`ifdef MOTOR_DAC_OFFSET_BINARY_EN
        return {8'h30, ~d[15], d[14:0]};
`else
        return {8'h30, d};
`endif
    endfunction

    logic [23:0] sb_q[$];
    bit          model_pend = 0;
    int          exp_ovr = 0;
    logic        en_rec = 0;
    logic [15:0] d_rec = '0;

    logic        sclk_p = 0, csn_p = 1;
    int          low_len = 0, bitn = 0, gap_len = 0, since_rise = 0;
    bit          busy_wait = 0, seen_frame = 0;
    logic [23:0] rx = '0, last_frame = '0;
    int          frames = 0, done_cnt = 0, ovr_cnt = 0;

    // SPI decoder plus reference model of the single-entry, latest-wins buffer.
    always @(negedge clk_i) begin
        if (rst_i) begin
            sb_q.delete();
            model_pend = 0;
            en_rec     = 0;
            sclk_p     = 0;
            csn_p      = 1;
            busy_wait  = 0;
            seen_frame = 0;
            bitn       = 0;
            low_len    = 0;
        end else begin
            if (csn_p && !dac_csn_o) begin
                model_pend = 0;
                if (seen_frame) chk("gap_min", gap_len >= 2, 1);
                low_len = 0;
                bitn    = 0;
            end
            if (en_rec) begin
                if (model_pend) begin
                    sb_q[sb_q.size()-1] = exp_frame(d_rec);
                    exp_ovr++;
                end else begin
                    sb_q.push_back(exp_frame(d_rec));
                end
                model_pend = 1;
            end
            en_rec = motor_dac_en_i;
            d_rec  = motor_dac_data_i;

            if (dac_done_o)    done_cnt++;
            if (dac_overrun_o) ovr_cnt++;

            if (!dac_csn_o) begin
                low_len++;
                if (sclk_p && !dac_sclk_o) begin
                    rx = {rx[22:0], dac_mosi_o};
                    bitn++;
                end
            end

            if (!csn_p && dac_csn_o) begin
                chk("csn_low_len", low_len, 98);
                chk("bit_count", bitn, 24);
                chk("done_at_csn_rise", dac_done_o, 1);
                chk("sb_nonempty", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) chk("frame", rx, sb_q.pop_front());
                last_frame = rx;
                frames++;
                gap_len    = 1;
                since_rise = 0;
                busy_wait  = 1;
                seen_frame = 1;
            end else if (dac_csn_o) begin
                gap_len++;
                if (busy_wait) begin
                    since_rise++;
                    if (!dac_busy_o) begin
                        chk("busy_drop_delay", since_rise, 2);
                        busy_wait = 0;
                    end
                end
            end
            sclk_p = dac_sclk_o;
            csn_p  = dac_csn_o;
        end
    end

    task automatic send(input logic [15:0] d);
        @(posedge clk_i); #1;
        motor_dac_en_i   = 1'b1;
        motor_dac_data_i = d;
        @(posedge clk_i); #1;
        motor_dac_en_i   = 1'b0;
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int k = 0;
        while (frames < n && k < budget) begin
            @(posedge clk_i);
            k++;
        end
        chk(tag, frames >= n, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
    endtask

    int          f0, o0, d0, k;
    logic [23:0] t2_exp;
    logic [9:0]  rv;

    initial begin
`ifdef MOTOR_DAC_OFFSET_BINARY_EN
        t2_exp = 24'h307F00;
`else
        t2_exp = 24'h30FF00;
`endif
        idle(3);
        #1;
        chk("reset_outputs", {dac_sclk_o, dac_csn_o, dac_mosi_o, dac_busy_o, dac_done_o, dac_overrun_o}, 6'b010000);
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        idle(2);

        // 1: single sample with latency check
        f0 = frames;
        @(posedge clk_i); #1;
        motor_dac_en_i   = 1'b1;
        motor_dac_data_i = 16'h0500;
        @(posedge clk_i); #1;
        motor_dac_en_i   = 1'b0;
        chk("latency_n1_csn_high", dac_csn_o, 1);
        @(posedge clk_i); #1;
        chk("latency_n2_csn_low", dac_csn_o, 0);
        chk("busy_at_start", dac_busy_o, 1);
        wait_frames("t1_wait", f0 + 1, 300);
        chk("t1_frame", last_frame, 24'h300500);
        idle(6);

        // 2: negative sample coding
        f0 = frames;
        send(16'hFF00);
        wait_frames("t2_wait", f0 + 1, 300);
        chk("t2_frame", last_frame, t2_exp);
        idle(6);

        // 3: overwrite of a pending sample during a frame
        f0 = frames;
        o0 = ovr_cnt;
        send(16'h0100);
        idle(20);
        send(16'h0200);
        idle(5);
        send(16'h0300);
        wait_frames("t3_wait", f0 + 2, 600);
        chk("t3_overruns", ovr_cnt - o0, 1);
        chk("t3_second_frame", last_frame, exp_frame(16'h0300));
        idle(6);

        // 4: samples arriving faster than frames drain
        f0 = frames;
        for (int i = 0; i < 10; i++) begin
            send(16'h1000 + 16'(i * 16'h0111));
            idle(48);
        end
        k = 0;
        while ((sb_q.size() != 0 || dac_busy_o) && k < 1000) begin
            @(posedge clk_i);
            k++;
        end
        chk("t4_drained", sb_q.size(), 0);
        chk("t4_last_frame", last_frame, exp_frame(16'h1000 + 16'h0999));
        idle(6);

        // 5: reset in the middle of a frame
        send(16'h1234);
        k = 0;
        while (bitn < 10 && k < 300) begin
            @(posedge clk_i);
            k++;
        end
        chk("t5_reached_bit10", bitn >= 10, 1);
        d0 = done_cnt;
        f0 = frames;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        chk("t5_csn_in_reset", dac_csn_o, 1);
        chk("t5_sclk_in_reset", dac_sclk_o, 0);
        idle(3);
        #2;
        rst_i = 1'b0;
        idle(150);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_no_frame", frames - f0, 0);
        send(16'h1357);
        wait_frames("t5_wait", f0 + 1, 300);
        chk("t5_fresh_frame", last_frame, exp_frame(16'h1357));
        idle(6);

        // 6: random small-amplitude stream, spaced beyond one frame
        f0 = frames;
        o0 = ovr_cnt;
        for (int i = 0; i < 20; i++) begin
            rv = 10'($urandom_range(0, 39)) - 10'd20;
            send({rv, 6'd0});
            idle(118);
        end
        wait_frames("t6_wait", f0 + 20, 400);
        chk("t6_overruns", ovr_cnt - o0, 0);
        idle(10);

        chk("sb_empty_end", sb_q.size(), 0);
        chk("done_vs_frames", done_cnt, frames);
        chk("overrun_total", ovr_cnt, exp_ovr);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
